// File: rtl/prog_loader.sv
// Boot loader for the nRisc system: receives a framed byte stream, fills instruction
// and data memory, and holds the core in reset until the frame checksum verifies.
module prog_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int IMEM_BASE  = 0,
  parameter int DMEM_BASE  = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Restart,
  input  logic [DATA_WIDTH-1:0] InByte,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [ADDR_WIDTH-1:0] IMemAddr,
  output logic [DATA_WIDTH-1:0] IMemData,
  output logic                  IMemWrite,
  output logic [ADDR_WIDTH-1:0] DMemAddr,
  output logic [DATA_WIDTH-1:0] DMemData,
  output logic                  DMemWrite,
  output logic                  CpuReset,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [2:0] {
    S_ICOUNT,
    S_IDATA,
    S_DCOUNT,
    S_DDATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] IBASE = ADDR_WIDTH'(IMEM_BASE);
  localparam logic [ADDR_WIDTH-1:0] DBASE = ADDR_WIDTH'(DMEM_BASE);

  state_t                  state_q, state_d;
  logic [7:0]              index_q, index_d;
  logic [DATA_WIDTH-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic                    in_ready_q, in_ready_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0]   imem_data_q, imem_data_d;
  logic                    imem_write_q, imem_write_d;
  logic [ADDR_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0]   dmem_data_q, dmem_data_d;
  logic                    dmem_write_q, dmem_write_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic [7:0]              index_inc;
  logic                    last_byte;
  logic [DATA_WIDTH-1:0]   sum_next;

  // Base + index, wrapping silently at the top of the address space.
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [7:0] idx);
    return base + ADDR_WIDTH'(idx);
  endfunction

  assign accept    = InValid && in_ready_q;
  assign index_inc = index_q + 8'd1;
  assign last_byte = (index_inc == 8'(count_q));
  assign sum_next  = sum_q + InByte;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    count_d      = count_q;
    sum_d        = sum_q;
    imem_write_d = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    dmem_write_d = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_data_d  = dmem_data_q;

    case (state_q)
      S_ICOUNT: if (accept) begin
        count_d = InByte;
        index_d = 8'd0;
        sum_d   = InByte;
        state_d = (InByte != '0) ? S_IDATA : S_DCOUNT;
      end
      S_IDATA: if (accept) begin
        imem_write_d = 1'b1;
        imem_addr_d  = wrap_addr(IBASE, index_q);
        imem_data_d  = InByte;
        sum_d        = sum_next;
        index_d      = index_inc;
        if (last_byte) state_d = S_DCOUNT;
      end
      S_DCOUNT: if (accept) begin
        count_d = InByte;
        index_d = 8'd0;
        sum_d   = sum_next;
        state_d = (InByte != '0) ? S_DDATA : S_CHECK;
      end
      S_DDATA: if (accept) begin
        dmem_write_d = 1'b1;
        dmem_addr_d  = wrap_addr(DBASE, index_q);
        dmem_data_d  = InByte;
        sum_d        = sum_next;
        index_d      = index_inc;
        if (last_byte) state_d = S_CHECK;
      end
      S_CHECK: if (accept) begin
        state_d = (InByte == sum_q) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: if (Restart) begin
        state_d = S_ICOUNT;
      end
      default: state_d = S_ICOUNT;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    in_ready_d  = (state_d != S_DONE) && (state_d != S_ERROR);
    cpu_reset_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_ICOUNT;
      index_q      <= 8'd0;
      count_q      <= '0;
      sum_q        <= '0;
      in_ready_q   <= 1'b1;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      imem_write_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_data_q  <= '0;
      dmem_write_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      count_q      <= count_d;
      sum_q        <= sum_d;
      in_ready_q   <= in_ready_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      imem_write_q <= imem_write_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_data_q  <= dmem_data_d;
      dmem_write_q <= dmem_write_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign InReady   = in_ready_q;
  assign IMemAddr  = imem_addr_q;
  assign IMemData  = imem_data_q;
  assign IMemWrite = imem_write_q;
  assign DMemAddr  = dmem_addr_q;
  assign DMemData  = dmem_data_q;
  assign DMemWrite = dmem_write_q;
  assign CpuReset  = cpu_reset_q;
  assign Done      = done_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (base 0 and wrapping base) share one
// byte stream; expected memory writes are queued on drive and popped on each strobe.
module tb_prog_loader;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Restart = 1'b0;
  logic       InValid = 1'b0;
  logic [7:0] InByte = 8'h00;

  logic       a_InReady, a_IMemWrite, a_DMemWrite, a_CpuReset, a_Done, a_Error;
  logic [7:0] a_IMemAddr, a_IMemData, a_DMemAddr, a_DMemData;
  logic       w_InReady, w_IMemWrite, w_DMemWrite, w_CpuReset, w_Done, w_Error;
  logic [7:0] w_IMemAddr, w_IMemData, w_DMemAddr, w_DMemData;

  localparam logic [7:0] W_IBASE = 8'hFE;
  localparam logic [7:0] W_DBASE = 8'hF0;

  prog_loader u_dut (
    .Clock(Clock), .Reset(Reset), .Restart(Restart), .InByte(InByte), .InValid(InValid),
    .InReady(a_InReady), .IMemAddr(a_IMemAddr), .IMemData(a_IMemData), .IMemWrite(a_IMemWrite),
    .DMemAddr(a_DMemAddr), .DMemData(a_DMemData), .DMemWrite(a_DMemWrite),
    .CpuReset(a_CpuReset), .Done(a_Done), .Error(a_Error)
  );

  prog_loader #(.IMEM_BASE(254), .DMEM_BASE(240)) u_wrap (
    .Clock(Clock), .Reset(Reset), .Restart(Restart), .InByte(InByte), .InValid(InValid),
    .InReady(w_InReady), .IMemAddr(w_IMemAddr), .IMemData(w_IMemData), .IMemWrite(w_IMemWrite),
    .DMemAddr(w_DMemAddr), .DMemData(w_DMemData), .DMemWrite(w_DMemWrite),
    .CpuReset(w_CpuReset), .Done(w_Done), .Error(w_Error)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] data;
  } wr_t;

  int         total = 0;
  int         bad = 0;
  int         iw_cnt = 0;
  int         dw_cnt = 0;
  wr_t        iexp[$];
  wr_t        dexp[$];
  logic [7:0] iq[$];
  logic [7:0] dq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge Clock) begin : mon
    wr_t e;
    chk("wrap_istrobe", 32'(w_IMemWrite), 32'(a_IMemWrite));
    chk("wrap_dstrobe", 32'(w_DMemWrite), 32'(a_DMemWrite));
    if (a_IMemWrite) begin
      iw_cnt++;
      total++;
      assert (iexp.size() > 0) else begin
        bad++;
        $error("FAIL imem_unexpected: observed strobe addr=%0h data=%0h expected none", a_IMemAddr, a_IMemData);
      end
      if (iexp.size() > 0) begin
        e = iexp.pop_front();
        chk("imem_addr", 32'(a_IMemAddr), 32'(e.idx));
        chk("imem_data", 32'(a_IMemData), 32'(e.data));
        chk("wrap_imem_addr", 32'(w_IMemAddr), 32'(8'(W_IBASE + e.idx)));
        chk("wrap_imem_data", 32'(w_IMemData), 32'(e.data));
      end
    end
    if (a_DMemWrite) begin
      dw_cnt++;
      total++;
      assert (dexp.size() > 0) else begin
        bad++;
        $error("FAIL dmem_unexpected: observed strobe addr=%0h data=%0h expected none", a_DMemAddr, a_DMemData);
      end
      if (dexp.size() > 0) begin
        e = dexp.pop_front();
        chk("dmem_addr", 32'(a_DMemAddr), 32'(e.idx));
        chk("dmem_data", 32'(a_DMemData), 32'(e.data));
        chk("wrap_dmem_addr", 32'(w_DMemAddr), 32'(8'(W_DBASE + e.idx)));
        chk("wrap_dmem_data", 32'(w_DMemData), 32'(e.data));
      end
    end
  end

  // Drive one byte after `gap` idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    repeat (gap) begin
      @(negedge Clock);
      InValid = 1'b0;
    end
    @(negedge Clock);
    InValid = 1'b1;
    InByte  = b;
    while (a_InReady !== 1'b1 && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    total++;
    assert (guard < 20) else begin
      bad++;
      $error("FAIL ready_timeout: waited=%0d cycles expected<20", guard);
    end
    @(posedge Clock);
    #1;
  endtask

  function automatic int gap_of(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
  endfunction

  // Send the frame held in iq/dq; checksum is corrupted by adding ck_adj.
  task automatic send_frame(input int maxgap, input logic [7:0] ck_adj);
    logic [7:0] sum;
    wr_t        e;
    logic       ok;
    sum = 8'(iq.size());
    send_byte(8'(iq.size()), gap_of(maxgap));
    for (int i = 0; i < iq.size(); i++) begin
      e.idx = 8'(i); e.data = iq[i];
      iexp.push_back(e);
      sum = sum + iq[i];
      send_byte(iq[i], gap_of(maxgap));
    end
    sum = sum + 8'(dq.size());
    send_byte(8'(dq.size()), gap_of(maxgap));
    for (int i = 0; i < dq.size(); i++) begin
      e.idx = 8'(i); e.data = dq[i];
      dexp.push_back(e);
      sum = sum + dq[i];
      send_byte(dq[i], gap_of(maxgap));
    end
    chk("cpureset_loading", 32'(a_CpuReset), 32'd1);
    chk("done_loading", 32'(a_Done), 32'd0);
    send_byte(sum + ck_adj, gap_of(maxgap));
    InValid = 1'b0;
    ok = (ck_adj == 8'h00);
    chk("done_after_ck", 32'(a_Done), 32'(ok));
    chk("error_after_ck", 32'(a_Error), 32'(!ok));
    chk("cpureset_after_ck", 32'(a_CpuReset), 32'(!ok));
    chk("inready_after_ck", 32'(a_InReady), 32'd0);
    chk("wrap_done_after_ck", 32'(w_Done), 32'(ok));
    chk("iexp_drained", 32'(iexp.size()), 32'd0);
    chk("dexp_drained", 32'(dexp.size()), 32'd0);
  endtask

  task automatic do_restart();
    @(negedge Clock);
    Restart = 1'b1;
    @(posedge Clock);
    #1;
    Restart = 1'b0;
    chk("restart_inready", 32'(a_InReady), 32'd1);
    chk("restart_cpureset", 32'(a_CpuReset), 32'd1);
    chk("restart_done", 32'(a_Done), 32'd0);
    chk("restart_error", 32'(a_Error), 32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_istrobe", 32'(a_IMemWrite), 32'd0);
    chk("rst_iaddr", 32'(a_IMemAddr), 32'd0);
    chk("rst_idata", 32'(a_IMemData), 32'd0);
    chk("rst_dstrobe", 32'(a_DMemWrite), 32'd0);
    chk("rst_daddr", 32'(a_DMemAddr), 32'd0);
    chk("rst_ddata", 32'(a_DMemData), 32'd0);
    chk("rst_cpureset", 32'(a_CpuReset), 32'd1);
    chk("rst_done", 32'(a_Done), 32'd0);
    chk("rst_error", 32'(a_Error), 32'd0);
    chk("rst_inready", 32'(a_InReady), 32'd1);
    chk("rst_wrap_iaddr", 32'(w_IMemAddr), 32'd0);
  endtask

  task automatic load_lists(input int ni, input int nd, input logic [7:0] seed);
    iq.delete();
    dq.delete();
    for (int i = 0; i < ni; i++) iq.push_back(8'(seed + 8'(i * 37)));
    for (int i = 0; i < nd; i++) dq.push_back(8'(seed ^ 8'(i * 11 + 5)));
  endtask

  initial begin
    int   iw0, dw0;
    wr_t  e;
    #2 Reset = 1'b1;
    #1 check_reset_values();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    // Basic frame 02,A1,B2,01,07,5D and its corrupted twin (CK=5C).
    iq.delete(); dq.delete();
    iq.push_back(8'hA1); iq.push_back(8'hB2); dq.push_back(8'h07);
    send_frame(0, 8'h00);
    do_restart();
    send_frame(0, 8'hFF);
    repeat (3) @(negedge Clock);
    chk("error_holds", 32'(a_Error), 32'd1);
    chk("error_cpureset", 32'(a_CpuReset), 32'd1);
    chk("error_inready", 32'(a_InReady), 32'd0);
    do_restart();
    send_frame(0, 8'h00);
    do_restart();

    // Empty frame 00,00,00 then 00,01,FF,00.
    iw0 = iw_cnt; dw0 = dw_cnt;
    iq.delete(); dq.delete();
    send_frame(0, 8'h00);
    chk("empty_no_iwrites", 32'(iw_cnt - iw0), 32'd0);
    chk("empty_no_dwrites", 32'(dw_cnt - dw0), 32'd0);
    do_restart();
    dq.push_back(8'hFF);
    send_frame(0, 8'h00);
    do_restart();

    // Ten instructions back-to-back, then the same frame with random gaps.
    load_lists(10, 2, 8'h3C);
    iw0 = iw_cnt;
    send_frame(0, 8'h00);
    chk("nogap_pulses", 32'(iw_cnt - iw0), 32'd10);
    do_restart();
    iw0 = iw_cnt;
    send_frame(5, 8'h00);
    chk("gap_pulses", 32'(iw_cnt - iw0), 32'd10);
    do_restart();

    // Four instructions land at FE,FF,00,01 on the wrapping instance.
    load_lists(4, 3, 8'h91);
    send_frame(2, 8'h00);
    do_restart();

    // Abandon a frame after 3 of 5 instruction bytes.
    send_byte(8'd5, 0);
    for (int i = 0; i < 3; i++) begin
      e.idx = 8'(i); e.data = 8'(8'h50 + 8'(i));
      iexp.push_back(e);
      send_byte(e.data, 0);
    end
    @(negedge Clock);
    #2;
    InValid = 1'b0;
    Reset = 1'b1;
    #1 check_reset_values();
    chk("abandon_drained", 32'(iexp.size()), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    load_lists(5, 1, 8'h22);
    send_frame(1, 8'h00);

    repeat (3) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
